// File: rtl/debug_port_sink_pkg.sv
// debug_port_sink_pkg: shared types and constants for the debug byte sink.
// Optional macro DEBUG_PORT_SINK_CHANGE_DETECT_EN is consumed by the top.
package debug_port_sink_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  // Cycles spent on one complete 8N1 frame.
  function automatic int frame_cycles(input int clks_per_bit);
    return FRAME_BITS * clks_per_bit;
  endfunction

endpackage

// File: rtl/debug_port_sink_fifo.sv
// debug_port_sink_fifo: synchronous FIFO with registered occupancy count.
// Head entry is presented combinationally on rdata (show-ahead).
module debug_port_sink_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset, pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap modulo DEPTH; count tracks net push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/debug_port_sink.sv
// debug_port_sink: queues debug-port bytes and sends them as 8N1 UART.
// Macro DEBUG_PORT_SINK_CHANGE_DETECT_EN: push on data change, not strobe.
module debug_port_sink
  import debug_port_sink_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    debug_data,
  input  logic                          debug_valid,
  input  logic                          overflow_clr,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic            push_req;
  logic            push_ok;
  logic            drop;
  logic            pop;
  logic            full;
  logic            empty;
  logic [7:0]      head;
  logic [CW-1:0]   count_next;

  tx_state_e       state_q;
  tx_state_e       state_d;
  logic [TW-1:0]   timer_q;
  logic [TW-1:0]   timer_d;
  logic [2:0]      bit_q;
  logic [2:0]      bit_d;
  logic [7:0]      shreg_q;
  logic [7:0]      shreg_d;
  logic            tx_q;
  logic            tx_d;
  logic            busy_q;
  logic            ovf_q;
  logic            timer_last;

`ifdef DEBUG_PORT_SINK_CHANGE_DETECT_EN
  logic [7:0] last_q;
  logic       unused_valid;

  assign unused_valid = debug_valid;
  assign push_req     = (debug_data != last_q);

  // Track the last level seen so a held value is only queued once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 8'h00;
    end else begin
      last_q <= debug_data;
    end
  end
`else
  assign push_req = debug_valid;
`endif

  // Full is judged on the registered count, so a same-cycle pop
  // cannot make room for an incoming byte.
  assign push_ok = push_req & ~full;
  assign drop    = push_req & full;

  debug_port_sink_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .wdata (debug_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign timer_last = (timer_q == TW'(CLKS_PER_BIT - 1));

  // Pop when idle, or in the final stop cycle for a gapless next frame.
  assign pop = ~empty &
               ((state_q == IDLE) |
                ((state_q == STOP) & timer_last));

  assign count_next = fifo_count
                    + CW'(push_ok)
                    - CW'(pop);

  // Next-state logic for the frame sequencer, bit timer and shifter.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        tx_d    = 1'b1;
        if (pop) begin
          state_d = START;
          shreg_d = head;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (timer_last) begin
          state_d = DATA;
          timer_d = '0;
          bit_d   = '0;
          tx_d    = shreg_q[0];
        end
      end
      DATA: begin
        if (timer_last) begin
          timer_d = '0;
          if (bit_q == 3'(DATA_BITS - 1)) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end
      end
      STOP: begin
        if (timer_last) begin
          timer_d = '0;
          if (pop) begin
            state_d = START;
            shreg_d = head;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Sequencer registers; the line itself comes straight off a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  // Busy reflects the state and occupancy being loaded this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= (state_d != IDLE) | (count_next != '0);
    end
  end

  // Sticky drop flag; a drop in the clearing cycle keeps it set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (overflow_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign uart_tx  = tx_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_debug_port_sink.sv
// tb_debug_port_sink: directed bench with a UART-decoding scoreboard.
// Covers both builds of DEBUG_PORT_SINK_CHANGE_DETECT_EN.
module tb_debug_port_sink;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic [7:0] debug_data;
  logic       debug_valid;
  logic       overflow_clr;
  logic       uart_tx;
  logic       busy;
  logic [2:0] fifo_count;
  logic       overflow;

  int n_cmp;
  int n_err;
  int cyc;
  int nframes;
  int mstate;
  int mcnt;
  logic [7:0] rx;
  logic [7:0] exp_q[$];
  int starts[$];

  debug_port_sink #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .debug_data   (debug_data),
    .debug_valid  (debug_valid),
    .overflow_clr (overflow_clr),
    .uart_tx      (uart_tx),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    debug_data  = b;
    debug_valid = 1'b1;
    exp_q.push_back(b);
    tick();
    debug_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && (exp_q.size() != 0 || busy !== 1'b0); i++)
      @(negedge clk);
    @(negedge clk);
    check("drain_queue", exp_q.size(), 0);
    check("drain_busy", busy, 0);
    tick();
  endtask

  // Line monitor: decodes frames mid-bit and scores them against exp_q.
  initial begin
    mstate = 0;
    mcnt = 0;
    rx = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst !== 1'b1) begin
        mstate = 0;
      end else if (mstate == 0) begin
        if (uart_tx === 1'b0) begin
          mstate = 1;
          mcnt = 0;
          starts.push_back(cyc);
        end
      end else begin
        mcnt++;
        if (mcnt == 2) begin
          check("start_bit", uart_tx, 0);
        end else if (mcnt >= 6 && mcnt <= 34 && (mcnt - 2) % 4 == 0) begin
          rx = {uart_tx, rx[7:1]};
        end else if (mcnt == 38) begin
          logic [8:0] e;
          check("stop_bit", uart_tx, 1);
          nframes++;
          e = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
          check("frame_data", {1'b0, rx}, e);
          mstate = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nf0;
    int lows;
    int gap;
    logic [9:0] f;
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    nframes = 0;
    rst = 1'b0;
    debug_data = 8'h00;
    debug_valid = 1'b0;
    overflow_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", uart_tx, 1);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 0);
    tick();
    rst = 1'b1;
    repeat (3) tick();

`ifdef DEBUG_PORT_SINK_CHANGE_DETECT_EN
    nf0 = nframes;
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check("zero_hold_lows", lows, 0);
    check("zero_hold_frames", nframes - nf0, 0);
    tick();

    nf0 = nframes;
    debug_data = 8'h3C;
    exp_q.push_back(8'h3C);
    tick();
    @(negedge clk);
    check("cd_3c_count", fifo_count, 1);
    @(negedge clk);
    check("cd_3c_tx", uart_tx, 0);
    repeat (100) @(negedge clk);
    check("cd_3c_frames", nframes - nf0, 1);
    check("cd_3c_queue", exp_q.size(), 0);
    tick();

    nf0 = nframes;
    debug_data = 8'h3D;
    exp_q.push_back(8'h3D);
    tick();
    @(negedge clk);
    check("cd_3d_count", fifo_count, 1);
    repeat (80) @(negedge clk);
    check("cd_3d_frames", nframes - nf0, 1);
    check("cd_3d_busy", busy, 0);
    check("cd_3d_queue", exp_q.size(), 0);
`else
    // Single byte: exact waveform and latency.
    push_byte(8'hA5);
    @(negedge clk);
    check("a5_n1_tx", uart_tx, 1);
    check("a5_n1_count", fifo_count, 1);
    check("a5_n1_busy", busy, 1);
    f = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("a5_wave", uart_tx, f[i / 4]);
      if (i == 0) check("a5_n2_count", fifo_count, 0);
      if (i == 39) check("a5_busy_last", busy, 1);
    end
    @(negedge clk);
    check("a5_idle_tx", uart_tx, 1);
    @(negedge clk);
    check("a5_busy_low", busy, 0);
    drain(100);

    // Burst of six: fill, drop the sixth, gapless frames.
    starts.delete();
    nf0 = nframes;
    for (int i = 0; i < 6; i++) begin
      debug_data = 8'(i + 1);
      debug_valid = 1'b1;
      if (i < 5) exp_q.push_back(8'(i + 1));
      @(negedge clk);
      if (i == 5) begin
        check("burst_count_full", fifo_count, 4);
        check("burst_ovf_pre", overflow, 0);
      end
      tick();
    end
    debug_valid = 1'b0;
    @(negedge clk);
    check("burst_ovf_set", overflow, 1);
    drain(400);
    check("burst_frames", nframes - nf0, 5);
    gap = (starts.size() >= 5) ? starts[4] - starts[0] : -1;
    check("burst_gapless", gap, 160);

    // Clear alone.
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    @(negedge clk);
    check("clr_alone", overflow, 0);
    tick();

    // Clear in the same cycle as a drop: drop wins.
    for (int i = 0; i < 6; i++) begin
      debug_data = 8'(8'h11 + i);
      debug_valid = 1'b1;
      if (i < 5) exp_q.push_back(8'(8'h11 + i));
      if (i == 5) overflow_clr = 1'b1;
      tick();
    end
    debug_valid = 1'b0;
    overflow_clr = 1'b0;
    @(negedge clk);
    check("clr_vs_drop", overflow, 1);
    tick();
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    @(negedge clk);
    check("clr_again", overflow, 0);
    drain(400);

    // Push and pop together at count 2.
    push_byte(8'hC1);
    push_byte(8'hC2);
    push_byte(8'hC3);
    repeat (38) @(posedge clk);
    #1;
    debug_data = 8'hC4;
    debug_valid = 1'b1;
    exp_q.push_back(8'hC4);
    @(negedge clk);
    check("pp_count_before", fifo_count, 2);
    check("pp_stop_tx", uart_tx, 1);
    tick();
    debug_valid = 1'b0;
    @(negedge clk);
    check("pp_count_after", fifo_count, 2);
    check("pp_start_tx", uart_tx, 0);
    drain(400);

    // Reset in the middle of a frame.
    for (int i = 0; i < 6; i++) begin
      debug_data = 8'(8'h61 + i);
      debug_valid = 1'b1;
      if (i < 5) exp_q.push_back(8'(8'h61 + i));
      tick();
    end
    debug_valid = 1'b0;
    repeat (15) tick();
    check("mid_ovf_pre", overflow, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_tx", uart_tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_ovf", overflow, 0);
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b1;
    nf0 = nframes;
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check("post_rst_lows", lows, 0);
    check("post_rst_frames", nframes - nf0, 0);
    check("post_rst_count", fifo_count, 0);
    tick();
    push_byte(8'h3E);
    drain(100);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
